turn_sequencer: RTL
===================

// Module: turn_sequencer
// PURPOSE
//  Game-turn controller directly upstream of the VGA UI renderer. Samples a debounced roll button,
//  draws a 1..6 die value, advances the active player's tile position and issues a one-cycle move
//  command (move_start_pN + target_x_pN). It waits for that player's turn_done before the turn
//  passes. Detects the winner at the flag tile and freezes the game.
// PARAMETERS
//  START_X        20          pixel x of tile 0 (target_x for position 0)
//  TILE_W         60          pixel width of one tile
//  TILE_COUNT     11          number of tiles, 2..16; last tile (TILE_COUNT-1) is the flag tile (x=620)
//  TIMEOUT_CYCLES 50_000_000  max cycles in WAIT_DONE before forcing turn end; 0 disables timeout
// PORTS
//  clk             in   1   system clock (pixel clock domain)
//  reset           in   1   asynchronous, active-high reset
//  roll_btn        in   1   debounced roll button, level; rising edge requests a roll
//  dbg_dice_en     in   1   1: use dbg_dice instead of internal die counter at roll sample
//  dbg_dice        in   3   forced die value; 0 treated as 1, 7 treated as 6
//  turn_done_p1    in   1   P1 movement finished (rising edge consumed)
//  turn_done_p2    in   1   P2 movement finished (rising edge consumed)
//  move_start_p1   out  1   one-cycle move command to P1 controller
//  target_x_p1     out  10  P1 destination pixel x, valid whenever move_start_p1=1, held otherwise
//  move_start_p2   out  1   one-cycle move command to P2 controller
//  target_x_p2     out  10  P2 destination pixel x
//  current_player  out  1   0=P1, 1=P2 (player whose turn it is)
//  dice_value      out  3   last rolled value 1..6, 0 before first roll
//  game_over       out  1   sticky, set when a player reaches the flag tile
//  winner          out  1   winning player id, valid when game_over=1
//  move_timeout    out  1   sticky, set if any WAIT_DONE expired
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, move_start_p*=0, target_x_p*=START_X, pos_p1=pos_p2=0,
//   current_player=0, dice_value=0, game_over=0, winner=0, move_timeout=0, die counter=1,
//   roll/done edge-detect regs=0. Reset asserted mid-turn aborts the turn; move_start drops at once.
//  Die counter: 3-bit, free-running. 1 after reset, +1 every clk, 6 wraps to 1.
//  Edge detect: registered previous value of roll_btn, turn_done_p1 and turn_done_p2.
//   edge = in & ~prev.
//  FSM: IDLE -> MOVE -> WAIT_DONE -> CHECK -> IDLE | GAME_OVER. All outputs registered.
//  IDLE: on roll edge sampled at clk edge k, at that same edge:
//   - d = dbg_dice_en ? clamp(dbg_dice) : counter; dice_value <= d.
//   - pos_cur <= min(pos_cur + d, TILE_COUNT-1). The sum uses 5 bits, so there is no wrap.
//   - target_x_cur <= START_X + new_pos*TILE_W (10-bit, ≤639 by parameter choice).
//   - state <= MOVE.
//  MOVE: lasts exactly 1 cycle; move_start_<current>=1 with the new target_x; then -> WAIT_DONE.
//   Inactive player's move_start and target_x unchanged.
//  WAIT_DONE: waits for a rising edge on turn_done_<current>, then -> CHECK.
//   - Inactive player's turn_done ignored.
//   - Level-high turn_done held over from an earlier turn does not count.
//   - Timeout counter clears on entry. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES
//     with no edge: move_timeout<=1, -> CHECK.
//   - Done edge and timeout in the same cycle: done wins, no timeout flag.
//  CHECK: 1 cycle.
//   - pos_cur==TILE_COUNT-1: game_over<=1, winner<=current_player, -> GAME_OVER.
//   - Else: current_player toggles, -> IDLE.
//  GAME_OVER: terminal until reset; all inputs ignored, outputs held.
//  Roll edges outside IDLE are dropped (not queued). Roll edge in the same cycle as state entering
//   IDLE is ignored; the roll must arrive while state==IDLE.
//  Latency: roll edge at edge k -> move_start high cycle k..k+1. Done edge at edge m -> CHECK at m,
//   next player's IDLE at m+1.
// TESTING
//  T1 reset, dbg_dice_en=1 dbg_dice=3, roll edge -> move_start_p1 high exactly 1 cycle,
//     target_x_p1=200, dice_value=3, p2 outputs unchanged.
//  T2 during WAIT_DONE: pulse roll_btn and turn_done_p2 -> no effect; then turn_done_p1 rises ->
//     current_player=1 two cycles later. Next roll (dbg 6) -> target_x_p2=380.
//  T3 P1 at pos 8, dbg 6 -> target_x_p1=620 (clamped at tile 10), done -> game_over=1, winner=0;
//     further roll edges produce no move_start.
//  T4 TIMEOUT_CYCLES=100, withhold turn_done -> move_timeout=1 after 100 WAIT cycles, turn passes
//     to P2; flag stays 1.
//  T5 assert reset mid-WAIT_DONE -> all outputs at reset values before next clk edge.
//     dbg_dice=0 -> dice 1; dbg_dice=7 -> dice 6.
//  T6 dbg_dice_en=0, roll edge sampled 4 cycles after reset release -> dice_value=5; rapid
//     held-high roll_btn yields a single roll.

Source files
------------

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - two-player roll/move/wait turn controller feeding the UI renderer
// Draws a die value, advances the active player's tile and waits for its movement to finish.
module turn_sequencer #(
  parameter int START_X        = 20,
  parameter int TILE_W         = 60,
  parameter int TILE_COUNT     = 11,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_btn,
  input  logic       dbg_dice_en,
  input  logic [2:0] dbg_dice,
  input  logic       turn_done_p1,
  input  logic       turn_done_p2,
  output logic       move_start_p1,
  output logic [9:0] target_x_p1,
  output logic       move_start_p2,
  output logic [9:0] target_x_p2,
  output logic       current_player,
  output logic [2:0] dice_value,
  output logic       game_over,
  output logic       winner,
  output logic       move_timeout
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [4:0] FLAG_POS = 5'(TILE_COUNT - 1);
  localparam logic [9:0] X0 = 10'(START_X);
  localparam logic [9:0] XW = 10'(TILE_W);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_WAIT, S_CHECK, S_OVER} state_t;

  state_t        state_q, state_d;
  logic [2:0]    die_q, die_d;
  logic          roll_prev_q, done1_prev_q, done2_prev_q;
  logic [4:0]    pos1_q, pos1_d, pos2_q, pos2_d;
  logic [9:0]    tx1_q, tx1_d, tx2_q, tx2_d;
  logic          ms1_q, ms1_d, ms2_q, ms2_d;
  logic          player_q, player_d;
  logic [2:0]    dice_q, dice_d;
  logic          over_q, over_d, winner_q, winner_d, timeout_q, timeout_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic       roll_edge, done_edge, timeout_hit;
  logic [2:0] die_pick;
  logic [4:0] pos_cur, pos_sum, pos_new;
  logic [9:0] tx_new;

  always_comb begin
    roll_edge   = roll_btn & ~roll_prev_q;
    done_edge   = player_q ? (turn_done_p2 & ~done2_prev_q) : (turn_done_p1 & ~done1_prev_q);
    timeout_hit = TO_EN && (tcnt_q == T_LAST);
    if (!dbg_dice_en)         die_pick = die_q;
    else if (dbg_dice == 3'd0) die_pick = 3'd1;
    else if (dbg_dice == 3'd7) die_pick = 3'd6;
    else                       die_pick = dbg_dice;
    pos_cur = player_q ? pos2_q : pos1_q;
    pos_sum = pos_cur + {2'b00, die_pick};
    pos_new = (pos_sum > FLAG_POS) ? FLAG_POS : pos_sum;
    tx_new  = X0 + XW * {5'b00000, pos_new};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      die_q        <= 3'd1;
      roll_prev_q  <= 1'b0;
      done1_prev_q <= 1'b0;
      done2_prev_q <= 1'b0;
      pos1_q       <= '0;
      pos2_q       <= '0;
      tx1_q        <= X0;
      tx2_q        <= X0;
      ms1_q        <= 1'b0;
      ms2_q        <= 1'b0;
      player_q     <= 1'b0;
      dice_q       <= 3'd0;
      over_q       <= 1'b0;
      winner_q     <= 1'b0;
      timeout_q    <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      die_q        <= die_d;
      roll_prev_q  <= roll_btn;
      done1_prev_q <= turn_done_p1;
      done2_prev_q <= turn_done_p2;
      pos1_q       <= pos1_d;
      pos2_q       <= pos2_d;
      tx1_q        <= tx1_d;
      tx2_q        <= tx2_d;
      ms1_q        <= ms1_d;
      ms2_q        <= ms2_d;
      player_q     <= player_d;
      dice_q       <= dice_d;
      over_q       <= over_d;
      winner_q     <= winner_d;
      timeout_q    <= timeout_d;
      tcnt_q       <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (roll_edge) state_d = S_MOVE;
      S_MOVE:  state_d = S_WAIT;
      S_WAIT:  if (done_edge || timeout_hit) state_d = S_CHECK;
      S_CHECK: state_d = (pos_cur == FLAG_POS) ? S_OVER : S_IDLE;
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  // move_start defaults low so it can only ever last the single MOVE cycle
  always_comb begin
    die_d     = (die_q == 3'd6) ? 3'd1 : die_q + 3'd1;
    pos1_d    = pos1_q;
    pos2_d    = pos2_q;
    tx1_d     = tx1_q;
    tx2_d     = tx2_q;
    ms1_d     = 1'b0;
    ms2_d     = 1'b0;
    player_d  = player_q;
    dice_d    = dice_q;
    over_d    = over_q;
    winner_d  = winner_q;
    timeout_d = timeout_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (roll_edge) begin
          dice_d = die_pick;
          if (player_q) begin
            pos2_d = pos_new;
            tx2_d  = tx_new;
            ms2_d  = 1'b1;
          end else begin
            pos1_d = pos_new;
            tx1_d  = tx_new;
            ms1_d  = 1'b1;
          end
        end
      end
      S_MOVE: tcnt_d = '0;
      S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!done_edge && timeout_hit) timeout_d = 1'b1;
      end
      S_CHECK: begin
        if (pos_cur == FLAG_POS) begin
          over_d   = 1'b1;
          winner_d = player_q;
        end else begin
          player_d = ~player_q;
        end
      end
      default: ;
    endcase
  end

  assign move_start_p1  = ms1_q;
  assign move_start_p2  = ms2_q;
  assign target_x_p1    = tx1_q;
  assign target_x_p2    = tx2_q;
  assign current_player = player_q;
  assign dice_value     = dice_q;
  assign game_over      = over_q;
  assign winner         = winner_q;
  assign move_timeout   = timeout_q;

endmodule
